// File: rtl/run_sequencer.sv
// Launches a single-shot worker req_count times per accepted request, with a
// per-launch clear pulse, a bounded enable window and an idle gap between launches.
//
// state | meaning
// IDLE  | ready for a request
// CLR   | one-cycle worker clear
// RUN   | worker enabled, waiting for done or timeout
// GAP   | worker disabled between launches
// DONE  | one-cycle completion pulse
module run_sequencer #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16,
  parameter int GAP     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_count,
  output logic             wk_en,
  output logic             wk_rst,
  input  logic             wk_done,
  output logic             busy,
  output logic [CNT_W-1:0] runs_done,
  output logic             seq_done,
  output logic             timeout_err
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LD = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] runs_q, runs_d;
  logic [CNT_W-1:0] runs_inc;
  logic [TW-1:0]    timer_q, timer_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             err_q, err_d;

  assign runs_inc = runs_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      runs_q  <= '0;
      timer_q <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      runs_q  <= runs_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    runs_d  = runs_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          count_d = req_count;
          runs_d  = '0;
          err_d   = 1'b0;
          state_d = (req_count == '0) ? S_DONE : S_CLR;
        end
      end
      S_CLR: begin
        timer_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        timer_d = timer_q + 1'b1;
        // done on the last allowed cycle still counts as a success
        if (wk_done) begin
          runs_d = runs_inc;
          if (runs_inc == count_q) begin
            state_d = S_DONE;
          end else if (GAP == 0) begin
            state_d = S_CLR;
          end else begin
            gap_d   = GAP_LD;
            state_d = S_GAP;
          end
        end else if (timer_q == TMAX) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_CLR;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign wk_rst      = (state_q == S_CLR);
  assign wk_en       = (state_q == S_RUN);
  assign seq_done    = (state_q == S_DONE);
  assign runs_done   = runs_q;
  assign timeout_err = err_q;

endmodule
